// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray/binary helpers.
// Both the read-side and write-side pointer blocks import this package.
package fifo_pkg;

  localparam int ADDR_BITS = 4;
  localparam int PTR_W     = ADDR_BITS + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    for (int i = 0; i < PTR_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parameterised Gray-to-binary converter (XOR prefix from the MSB down).
// Pure combinational; also used by the write-side level logic.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    // Bit i is the XOR of all Gray bits at or above i.
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain pointer and flag stage of the async FIFO: binary/Gray read pointer,
// RAM read address, and registered empty, almost-empty, level and sticky underflow.
module fifo_rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS = fifo_pkg::ADDR_BITS,
  parameter int AE_THRESH = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic                 r_en,
  input  logic [ADDR_BITS:0]   r_wptr_sync,
  input  logic                 r_underflow_clr,
  output logic [ADDR_BITS:0]   r_ptr,
  output logic [ADDR_BITS-1:0] r_addr,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic [ADDR_BITS:0]   r_count,
  output logic                 r_underflow
);

  localparam int PW = ADDR_BITS + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_bin_next;
  logic [PW-1:0] r_gray_next;
  logic [PW-1:0] w_bin;
  logic [PW-1:0] level_next;
  logic          rd_ok;

  fifo_gray2bin #(.W(PW)) u_wptr_g2b (
    .gray (r_wptr_sync),
    .bin  (w_bin)
  );

  always_comb begin
    rd_ok       = r_en & ~r_empty;
    r_bin_next  = r_bin + PW'(rd_ok);
    r_gray_next = r_bin_next ^ (r_bin_next >> 1);
    // Modulo subtraction stays correct across pointer wrap without special casing.
    level_next  = w_bin - r_bin_next;
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_count        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= r_bin_next;
      r_ptr          <= r_gray_next;
      r_empty        <= (r_gray_next == r_wptr_sync);
      r_almost_empty <= (level_next <= AE_LIMIT);
      r_count        <= level_next;
      // A new underflow event takes priority over a clear in the same cycle.
      if (r_en && r_empty) begin
        r_underflow <= 1'b1;
      end else if (r_underflow_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign r_addr = r_bin[ADDR_BITS-1:0];

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Self-checking bench for fifo_rd_ptr_empty (ADDR_BITS=4, AE_THRESH=2).
// Expected outputs are pushed to a queue as stimulus is driven and compared after the edge.
module tb_fifo_rd_ptr_empty;

  localparam int AB = 4;
  localparam int PW = AB + 1;

  typedef struct packed {
    logic [PW-1:0] ptr;
    logic [AB-1:0] addr;
    logic          empty;
    logic          ae;
    logic [PW-1:0] count;
    logic          uf;
    logic          adv;
  } exp_t;

  logic          r_clk = 1'b0;
  logic          r_rst_n;
  logic          r_en;
  logic [PW-1:0] r_wptr_sync;
  logic          r_underflow_clr;
  logic [PW-1:0] r_ptr;
  logic [AB-1:0] r_addr;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_count;
  logic          r_underflow;

  fifo_rd_ptr_empty #(.ADDR_BITS(AB), .AE_THRESH(2)) dut (
    .r_clk           (r_clk),
    .r_rst_n         (r_rst_n),
    .r_en            (r_en),
    .r_wptr_sync     (r_wptr_sync),
    .r_underflow_clr (r_underflow_clr),
    .r_ptr           (r_ptr),
    .r_addr          (r_addr),
    .r_empty         (r_empty),
    .r_almost_empty  (r_almost_empty),
    .r_count         (r_count),
    .r_underflow     (r_underflow)
  );

  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  logic [PW-1:0] m_bin   = '0;
  logic          m_empty = 1'b1;
  logic          m_uf    = 1'b0;
  logic [PW-1:0] prev_ptr = '0;
  logic [PW-1:0] w_cnt   = '0;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  function automatic logic [PW-1:0] from_gray(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
  task automatic cyc(input logic rst_n, input logic en, input logic [PW-1:0] wg,
                     input logic clr);
    exp_t e;
    logic [PW-1:0] nb, lvl;
    logic rd;
    r_rst_n = rst_n; r_en = en; r_wptr_sync = wg; r_underflow_clr = clr;
    if (!rst_n) begin
      e = '{ptr: '0, addr: '0, empty: 1'b1, ae: 1'b1, count: '0, uf: 1'b0, adv: 1'b0};
      m_bin = '0; m_empty = 1'b1; m_uf = 1'b0;
    end else begin
      rd  = en && !m_empty;
      nb  = m_bin + (rd ? 5'd1 : 5'd0);
      lvl = from_gray(wg) - nb;
      if (en && m_empty) m_uf = 1'b1;
      else if (clr)      m_uf = 1'b0;
      m_bin = nb; m_empty = (lvl == 0);
      e = '{ptr: to_gray(nb), addr: nb[AB-1:0], empty: (lvl == 0), ae: (lvl <= 2),
            count: lvl, uf: m_uf, adv: rd};
    end
    sb_q.push_back(e);
    @(posedge r_clk);
    #1;
    e = sb_q.pop_front();
    check("r_ptr",          int'(r_ptr),          int'(e.ptr));
    check("r_addr",         int'(r_addr),         int'(e.addr));
    check("r_empty",        int'(r_empty),        int'(e.empty));
    check("r_almost_empty", int'(r_almost_empty), int'(e.ae));
    check("r_count",        int'(r_count),        int'(e.count));
    check("r_underflow",    int'(r_underflow),    int'(e.uf));
    if (e.adv) check("gray_one_bit", $countones(r_ptr ^ prev_ptr), 1);
    prev_ptr = r_ptr;
  endtask

  initial begin
    r_rst_n = 1'b0; r_en = 1'b1; r_wptr_sync = '0; r_underflow_clr = 1'b0;

    // Reset held with reads requested, then released idle.
    repeat (3) cyc(1'b0, 1'b1, 5'd0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 5'd0, 1'b0);

    // Fill: Gray 1, 3, 2.
    cyc(1'b1, 1'b0, 5'd1, 1'b0);
    cyc(1'b1, 1'b0, 5'd3, 1'b0);
    cyc(1'b1, 1'b0, 5'd2, 1'b0);
    check("fill_count", int'(r_count), 3);
    check("fill_ae", int'(r_almost_empty), 0);

    // Drain 3 words plus one underflowing read.
    repeat (4) cyc(1'b1, 1'b1, 5'd2, 1'b0);
    check("drain_addr", int'(r_addr), 3);
    check("drain_uf", int'(r_underflow), 1);
    cyc(1'b1, 1'b0, 5'd2, 1'b1);
    check("uf_clear", int'(r_underflow), 0);

    // Wrap: 40 writes and 40 reads interleaved.
    w_cnt = 5'd3;
    for (int i = 0; i < 40; i++) begin
      w_cnt = w_cnt + 5'd1;
      cyc(1'b1, 1'b0, to_gray(w_cnt), 1'b0);
      cyc(1'b1, 1'b1, to_gray(w_cnt), 1'b0);
    end
    check("wrap_bin", int'(r_addr), 11);
    check("wrap_uf", int'(r_underflow), 0);

    // Full level after a fresh reset.
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 1'b0, to_gray(5'd16), 1'b0);
    check("full_count", int'(r_count), 16);
    cyc(1'b1, 1'b1, to_gray(5'd16), 1'b0);
    check("full_minus1", int'(r_count), 15);

    // Mid-burst reset at r_bin=7.
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 1'b0, to_gray(5'd10), 1'b0);
    repeat (7) cyc(1'b1, 1'b1, to_gray(5'd10), 1'b0);
    check("pre_reset_addr", int'(r_addr), 7);
    cyc(1'b0, 1'b1, to_gray(5'd10), 1'b0);
    check("midreset_empty", int'(r_empty), 1);

    // Underflow set and clear in the same cycle: set wins.
    cyc(1'b1, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, 5'd0, 1'b1);
    check("uf_set_wins", int'(r_underflow), 1);
    cyc(1'b1, 1'b0, 5'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
